// File: rtl/adder_tree_in_packer.sv
// Stream-to-vector packer feeding adder_tree_var_bit: collects NUM signed words,
// zero-pads frames ended early by in_last, and delays out_valid to line up with the tree sum.
module adder_tree_in_packer #(
    parameter int NUM      = 18,
    parameter int LEN      = 16,
    parameter int TREE_LAT = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LEN-1:0]      in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [NUM*LEN-1:0]  out_vec,
    output logic                out_valid,
    output logic                out_last,
    output logic                sum_valid,
    output logic [15:0]         vec_count
);
    localparam int W  = NUM * LEN;
    localparam int CW = $clog2(NUM);

    typedef enum logic {FILL, FLUSH} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [CW-1:0]   rem, rem_nx;
    logic [W-1:0]    shreg, shreg_nx, shifted;
    logic [LEN-1:0]  shift_word;
    logic            accept;
    logic            emit, emit_last;
    logic [TREE_LAT-1:0] vld_pipe;

    assign in_ready = (state == FILL) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        rem_nx     = rem;
        shreg_nx   = shreg;
        emit       = 1'b0;
        emit_last  = 1'b0;
        // FLUSH pads with zero words; FILL takes the incoming word.
        shift_word = (state == FLUSH) ? '0 : in_data;
        shifted    = {shreg[W-LEN-1:0], shift_word};
        case (state)
            FILL: begin
                if (accept) begin
                    shreg_nx = shifted;
                    if (cnt == CW'(NUM-1)) begin
                        emit      = 1'b1;
                        emit_last = in_last;
                        cnt_nx    = '0;
                    end else if (in_last) begin
                        rem_nx   = CW'(NUM-1) - cnt;
                        state_nx = FLUSH;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            FLUSH: begin
                shreg_nx = shifted;
                rem_nx   = rem - 1'b1;
                if (rem == CW'(1)) begin
                    emit      = 1'b1;
                    emit_last = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            rem       <= '0;
            shreg     <= '0;
            out_vec   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            vec_count <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rem       <= rem_nx;
            shreg     <= shreg_nx;
            out_valid <= emit;
            if (emit) begin
                out_vec   <= shreg_nx;
                out_last  <= emit_last;
                vec_count <= vec_count + 16'd1;
            end
        end
    end

    // out_valid delayed to the cycle the tree presents the sum of this vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= out_valid;
            for (int i = 1; i < TREE_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign sum_valid = vld_pipe[TREE_LAT-1];

endmodule

// File: tb/tb_adder_tree_in_packer.sv
// Directed bench for adder_tree_in_packer with a scoreboard of expected vectors and cycles.
module tb_adder_tree_in_packer;
    localparam int NUM = 18, LEN = 16, TL = 5, W = NUM*LEN;

    logic           clk = 1'b0, rst = 1'b1;
    logic [LEN-1:0] in_data = '0;
    logic           in_valid = 1'b0, in_last = 1'b0;
    logic           in_ready, out_valid, out_last, sum_valid;
    logic [W-1:0]   out_vec;
    logic [15:0]    vec_count;

    adder_tree_in_packer #(.NUM(NUM), .LEN(LEN), .TREE_LAT(TL)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_vec(out_vec), .out_valid(out_valid), .out_last(out_last),
        .sum_valid(sum_valid), .vec_count(vec_count));

    always #5 clk = ~clk;

    typedef struct {logic [W-1:0] vec; logic last; int sum; int cyc;} exp_t;
    exp_t           expq[$];
    int             svq[$];
    logic [LEN-1:0] words[$];
    int checks = 0, errors = 0, cyc = 0, nvec = 0;
    int acc, st, stalls;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Close the modelled frame: pad to NUM words, first word in the top slice.
    task automatic push_vec(input logic last, input int at);
        exp_t e;
        e.vec = '0; e.sum = 0; e.last = last; e.cyc = at;
        for (int i = 0; i < words.size(); i++) begin
            e.vec[W-1-i*LEN -: LEN] = words[i];
            e.sum += int'($signed(words[i]));
        end
        expq.push_back(e);
        words.delete();
        nvec++;
    endtask

    task automatic send(input logic [LEN-1:0] d, input logic last, output int a, output int s);
        int k;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; s = 0;
        while (!in_ready && s < 100) begin @(negedge clk); s++; end
        if (!in_ready) begin
            checks++; errors++;
            $error("FAIL send_timeout: observed in_ready 0 expected 1");
            in_valid = 1'b0; a = -1;
            return;
        end
        @(posedge clk); #1;
        a = cyc;
        words.push_back(d);
        k = words.size();
        if (last || k == NUM) push_vec(last, a + ((k == NUM) ? 0 : NUM - k));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    exp_t e;
    int   s;
    always @(negedge clk) begin
        if (out_valid) begin
            if (expq.size() == 0) begin
                checks++; errors++;
                $error("FAIL unexpected_out_valid: observed 1 at cycle %0d expected 0", cyc);
            end else begin
                e = expq.pop_front();
                chk("out_vec", out_vec, e.vec);
                chk("out_last", out_last, e.last);
                chk("out_valid_cycle", cyc, e.cyc);
                s = 0;
                for (int i = 0; i < NUM; i++) s += int'($signed(out_vec[i*LEN +: LEN]));
                chk("tree_sum", s, e.sum);
            end
            svq.push_back(cyc);
        end
        if (sum_valid) begin
            if (svq.size() == 0) begin
                checks++; errors++;
                $error("FAIL unexpected_sum_valid: observed 1 at cycle %0d expected 0", cyc);
            end else chk("sum_valid_cycle", cyc, svq.pop_front() + TL);
        end
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_vec", out_vec, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_vec_count", vec_count, 0);
        rst = 1'b0; #1;
        chk("in_ready_after_rst", in_ready, 1);

        // ones
        for (int i = 0; i < NUM; i++) send(16'h0001, 1'b0, acc, st);
        idle(10);
        chk("vec_count_ones", vec_count, nvec);

        // ordering, then all -1
        for (int i = 0; i < NUM; i++) send(LEN'(i+1), 1'b0, acc, st);
        for (int i = 0; i < NUM; i++) send(16'hFFFF, 1'b0, acc, st);
        idle(10);
        chk("vec_count_order", vec_count, nvec);

        // partial frame of 5 threes
        for (int i = 0; i < 5; i++) send(16'd3, i == 4, acc, st);
        in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < NUM-5; i++) begin @(negedge clk); chk("in_ready_flush5", in_ready, 0); end
        @(negedge clk); chk("in_ready_after_flush5", in_ready, 1);
        idle(10);

        // back-to-back, 36 continuous words
        stalls = 0;
        for (int i = 0; i < 2*NUM; i++) begin
            send(LEN'($urandom), 1'b0, acc, st);
            stalls += st;
        end
        chk("b2b_stalls", stalls, 0);
        idle(10);
        chk("vec_count_b2b", vec_count, nvec);

        // reset on the 4th flush cycle discards the frame
        send(16'd7, 1'b0, acc, st);
        send(16'd9, 1'b1, acc, st);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk); rst = 1'b1; #1;
        chk("in_ready_in_rst", in_ready, 0);
        @(negedge clk); rst = 1'b0;
        expq.delete(); words.delete(); nvec = 0;
        chk("midflush_out_vec", out_vec, 0);
        chk("midflush_out_valid", out_valid, 0);
        chk("midflush_vec_count", vec_count, 0);
        #1 chk("midflush_in_ready", in_ready, 1);
        idle(25);
        for (int i = 0; i < NUM; i++) send(LEN'($urandom), 1'b0, acc, st);
        idle(10);
        chk("vec_count_post_rst", vec_count, nvec);

        // in_valid gaps, in_last on the NUM-th word
        for (int i = 0; i < NUM; i++) begin
            send(LEN'(100 + i), i == NUM-1, acc, st);
            idle(1);
        end
        chk("in_ready_no_flush", in_ready, 1);
        idle(10);

        // degenerate single-word frame
        send(16'h8001, 1'b1, acc, st);
        in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < NUM-1; i++) begin @(negedge clk); chk("in_ready_flush1", in_ready, 0); end
        @(negedge clk); chk("in_ready_after_flush1", in_ready, 1);

        idle(20);
        chk("expq_drained", expq.size(), 0);
        chk("svq_drained", svq.size(), 0);
        chk("vec_count_final", vec_count, nvec);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $error("FAIL global_timeout: observed time limit expected finish");
        $fatal(1);
    end
endmodule
